// File: rtl/reg_file_dump_reader.sv
// Walks register-file addresses 0..NUM_REGS-1 and streams {addr, data} beats with a last flag.
// 2 cycles per beat minimum (READ then HOLD); a beat holds in HOLD until out_ready, and abort drops back to IDLE.
module reg_file_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [4:0]            r_idx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [4:0]            r_out_addr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  w_hs;

    assign w_hs = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 5'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_addr  <= 5'd0;
            r_out_data  <= '0;
        end else begin
            r_done <= 1'b0;
            // abort outranks any handshake or transition on the same edge
            if (abort && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_idx   <= 5'd0;
                            r_busy  <= 1'b1;
                            r_state <= S_READ;
                        end
                    end
                    S_READ: begin
                        r_out_data  <= rd_data;
                        r_out_addr  <= r_idx;
                        r_out_last  <= (r_idx == LAST_IDX);
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (w_hs) begin
                            r_out_valid <= 1'b0;
                            if (r_out_last) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_idx   <= r_idx + 5'd1;
                                r_state <= S_READ;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_addr   = r_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Randomized bench for reg_file_dump_reader: a register-file array plus a beat scoreboard
// that expects addresses 0..31 in order, with each value taken from the array when the beat is accepted.
module tb_reg_file_dump_reader;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;

    logic [31:0] rf [NR];
    logic [31:0] got [NR];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int exp_idx = 0;
    int beats = 0;
    int dones = 0;
    int first_v = -1;
    int done_cyc = -1;
    int start_cyc = 0;
    bit p_busy = 0;
    bit p_stall = 0;
    bit p_abort = 0;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        p_last;

    reg_file_dump_reader #(.DATA_WIDTH(32), .NUM_REGS(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // register 0 is hard-wired to zero by the register file itself
    always_comb begin
        rd_data = 32'd0;
        if (rd_addr != 5'd0) rd_data = rf[rd_addr];
    end

    function automatic logic [31:0] model_val(input int i);
        return (i == 0) ? 32'd0 : rf[i];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        cyc++;
        if (!reset) begin
            exp_idx = 0; beats = 0; dones = 0; first_v = -1;
            p_busy = 0; p_stall = 0; p_abort = 0;
            return;
        end
        if (busy && !p_busy) begin
            exp_idx = 0; beats = 0; dones = 0; first_v = -1;
        end
        if (p_stall && !p_abort) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_addr", {27'd0, out_addr}, {27'd0, p_addr});
            chk("hold_data", out_data, p_data);
            chk("hold_last", {31'd0, out_last}, {31'd0, p_last});
        end
        if (out_valid && first_v < 0) first_v = cyc;
        if (out_valid && out_ready) begin
            if (exp_idx < NR) begin
                chk("beat_addr", {27'd0, out_addr}, 32'(exp_idx));
                chk("beat_data", out_data, model_val(exp_idx));
                chk("beat_last", {31'd0, out_last}, (exp_idx == NR - 1) ? 32'd1 : 32'd0);
                got[exp_idx] = out_data;
            end else begin
                chk("extra_beat", 32'(exp_idx), 32'(NR - 1));
            end
            beats++;
            exp_idx++;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
            chk("done_after_last", 32'(beats), 32'(NR));
        end
        p_stall = out_valid && !out_ready;
        p_abort = abort;
        p_addr  = out_addr;
        p_data  = out_data;
        p_last  = out_last;
        p_busy  = busy;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_addr"}, {27'd0, out_addr}, 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_rdaddr"}, {27'd0, rd_addr}, 32'd0);
    endtask

    // scen: 3 = restart pulse on beat 5, 4 = abort at idx 10, 5 = reset at idx 20,
    //       6 = write reg 31 at idx 15, 7 = random writes to not-yet-read registers
    task automatic run_dump(input int mode, input int scen, input int pct);
        bit fired = 0;
        start = 1'b1;
        start_cyc = cyc + 1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 600; k++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = ($urandom_range(0, 99) < pct);
            endcase
            start = 1'b0;
            if (scen == 3 && out_valid && out_addr == 5'd5 && !fired) begin
                start = 1'b1;
                fired = 1;
            end
            if (scen == 4 && out_valid && out_addr == 5'd10) begin
                out_ready = 1'b0;
                abort = 1'b1;
            end
            if (scen == 5 && out_valid && out_addr == 5'd20) begin
                #2 reset = 1'b0;
                #1 chk_reset_vals("async_rst");
                return;
            end
            if (scen == 6 && out_valid && out_addr == 5'd15 && !fired) begin
                rf[31] = 32'hDEAD_BEEF;
                fired = 1;
            end
            if (scen == 7 && exp_idx < NR - 1 && $urandom_range(0, 7) == 0)
                rf[$urandom_range(exp_idx + 1, NR - 1)] = $urandom;
            tick();
            if (abort) begin
                abort = 1'b0;
                chk("abort_valid", {31'd0, out_valid}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                return;
            end
            if (dones > 0) return;
        end
        chk("dump_timeout", 32'(dones), 32'd1);
    endtask

    task automatic preload();
        for (int i = 0; i < NR; i++) rf[i] = 32'hA000_0000 + 32'(i);
    endtask

    task automatic chk_full(input string tag);
        repeat (3) tick();
        chk({tag, "_beats"}, 32'(beats), 32'(NR));
        chk({tag, "_dones"}, 32'(dones), 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        preload();
        #1 reset = 1'b0;
        #2 chk_reset_vals("por");
        tick(); tick();
        reset = 1'b1;
        tick();

        // full dump, always ready: timing and content
        preload();
        run_dump(0, 1, 100);
        chk_full("t1");
        chk("t1_first_valid", 32'(first_v - start_cyc), 32'd2);
        chk("t1_done_cycle", 32'(done_cyc - start_cyc), 32'd65);
        chk("t1_reg0", got[0], 32'd0);
        chk("t1_reg5", got[5], 32'hA000_0005);
        chk("t1_reg31", got[31], 32'hA000_001F);

        // ready 1-in-3 backpressure
        run_dump(1, 2, 0);
        chk_full("t2");
        chk("t2_reg31", got[31], 32'hA000_001F);

        // start pulse mid-dump is ignored
        run_dump(0, 3, 100);
        repeat (4) tick();
        chk_full("t3");

        // abort while holding idx 10, then a clean full dump
        run_dump(0, 4, 100);
        repeat (5) tick();
        chk("t4_no_done", 32'(dones), 32'd0);
        chk("t4_beats", 32'(beats), 32'd10);
        run_dump(0, 0, 100);
        chk_full("t4b");
        chk("t4b_reg1", got[1], 32'hA000_0001);

        // reset at idx 20, stays idle afterwards
        run_dump(0, 5, 100);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (8) begin
            tick();
            chk("t5_idle", {30'd0, out_valid, busy}, 32'd0);
        end
        chk("t5_beats", 32'(beats), 32'd0);

        // write to reg 31 during the dump becomes visible
        preload();
        run_dump(0, 6, 100);
        chk_full("t6");
        chk("t6_reg31", got[31], 32'hDEAD_BEEF);

        // random contents, random backpressure, random in-flight writes
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NR; i++) rf[i] = $urandom;
            run_dump(2, 7, $urandom_range(20, 100));
            chk_full("t7");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
